data_mem_ctrl: RTL
==================

# data_mem_ctrl

- Byte-addressed RV32I data memory with a valid/ready request port and a registered response port.
- Supports every load/store width encoded by funct3: LB, LH, LW, LBU, LHU, SB, SH, SW.
- Sign/zero-extends load data; stores through per-byte lanes.
- Word-boundary-crossing accesses are either split into two beats or rejected with an error.
- Sits between the execute/memory stage and word-organised RAM.
- Parametrised successor to the single-cycle byte/word data memory.

## Interface
- ADDRESS_WIDTH, 32, request address width
- DATA_WIDTH, 32, data width; fixed to 32 (4 byte lanes)
- ADDR_BITS, 17, implemented byte-address bits; capacity 2**ADDR_BITS bytes (0x00000–0x1FFFF)
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 width/sign code
- req_addr  in  ADDRESS_WIDTH  byte address; bits above ADDR_BITS ignored (wrap)
- req_wdata  in  DATA_WIDTH  store data, right-aligned
- rsp_valid  out  1  one-cycle pulse marking a completed request
- rsp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors
- rsp_err  out  1  request rejected; valid only with rsp_valid

## Operation
- **States:** IDLE, SPLIT.
- **Handshake:** req_ready = (state == IDLE). A request is accepted when req_valid && req_ready. Inputs are sampled only on acceptance.
- **Lane selection:**
  - word index = addr[ADDR_BITS-1:2]; offset = addr[1:0]; size 1/2/4 bytes from funct3[1:0].
  - Byte enables = size mask << offset.
  - Store data is lane-shifted by offset.
- **Crossing access:** offset + size > 4 (LH/SH at offset 3; LW/SW at offset 1–3).
- **Non-crossing access:** one beat; the RAM write or read happens on the acceptance edge; state stays IDLE.
- **Crossing access, split (macro on):**
  - Beat 1 on the acceptance edge: low word, upper lanes. Read bytes go to a hold register.
  - IDLE→SPLIT.
  - Beat 2 on the next edge: word index+1 (wraps at top of memory), lower lanes. SPLIT→IDLE.
- **Load result:** reassemble bytes little-endian. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- **Illegal funct3:** loads 011/110/111, stores 011–111. No write, rsp_err = 1, one-beat latency.
- **Memory contents:** not reset; contents are undefined until written.

## Timing
- **Reset values:** req_ready 1 (after reset), rsp_valid 0, rsp_rdata 0, rsp_err 0, state IDLE.
- **Latency:**
  - Non-crossing and error requests: rsp_valid one cycle after acceptance.
  - Split requests: rsp_valid two cycles after acceptance; req_ready is 0 for exactly one cycle.
- **Throughput:** back-to-back non-crossing requests are accepted every cycle, with responses every cycle.
- **No response backpressure:** the consumer must take rsp_valid the cycle it is high.
- **Write-then-read:** a store followed immediately by a load to the same bytes returns the new data.
- **Reset during SPLIT:** the beat-2 access is abandoned and no response is issued. A beat-1 store write is already committed.
- **Response registers:** rsp_rdata/rsp_err hold their last value while rsp_valid is 0, except at reset.

## Configuration
- **DMEM_MISALIGNED_EN defined:** crossing accesses split into two beats as above.
- **DMEM_MISALIGNED_EN undefined:**
  - A crossing access performs no write.
  - The response is rsp_err = 1, rsp_rdata = 0 after one cycle.
  - The SPLIT state and hold register are not compiled.

## Structure
- **Package dmem_pkg:**
  - funct3 localparams (F3_B = 000, F3_H = 001, F3_W = 010, F3_BU = 100, F3_HU = 101)
  - state enum dmem_state_t {IDLE, SPLIT}
  - size/byte-enable helper functions
- **Sub-module dmem_byte_ram:** 2**(ADDR_BITS-2) × 32 words, 4-bit byte-enable synchronous write, synchronous read of one word per cycle.
- **data_mem_ctrl:** holds the FSM, lane shifting, extension and response registers.

## Test plan
- **Aligned word:** SW 0xDEADBEEF @0x100, then LW @0x100 → rsp_rdata 0xDEADBEEF, rsp_err 0; each response 1 cycle after acceptance.
- **Byte and half extension:** SB 0x80 @0x203, then LB @0x203 → 0xFFFFFF80; LBU → 0x00000080. SH 0x8001 @0x206, then LH → 0xFFFF8001.
- **Split word (macro on):** SW 0x11223344 @0x301 → req_ready low 1 cycle, rsp_valid at +2. LW @0x301 → 0x11223344. LW @0x300 → 0x223344xx, where xx is the byte @0x300.
- **Split word (macro off):** SW @0x301 → rsp_err 1 at +1; LW @0x300 is unchanged.
- **Illegal funct3 and back-to-back:**
  - Load funct3 = 011 → rsp_err 1.
  - Four consecutive aligned LW requests → four consecutive rsp_valid cycles.
- **Reset during SPLIT:** assert rst_n = 0 during a split SW @0x3FE → no rsp_valid; outputs at reset values; bytes 0x3FE–0x3FF written, 0x400–0x401 unchanged.

Source files
------------

// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the RV32I data memory controller.
//   - RV32I load/store funct3 codes
//   - controller state encoding
//   - helpers that derive access size, lane mask and legality from funct3
// -----------------------------------------------------------------------------
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } dmem_state_t;

    // Access size in bytes (1, 2 or 4). Only meaningful for legal codes.
    function automatic logic [2:0] f3_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Right-aligned byte-lane mask for the access size.
    function automatic logic [3:0] f3_mask(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Stores accept only B/H/W; loads additionally accept BU/HU.
    function automatic logic f3_legal(input logic [2:0] f3, input logic we);
        logic store_ok;
        store_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (we) begin
            return store_ok;
        end
        return store_ok || (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// -----------------------------------------------------------------------------
// dmem_byte_ram
// Word-organised RAM with one byte-wide array per lane so each lane can be
// written independently. Read is synchronous and only updates the output
// register when rd_en is high, so the last read word stays visible.
// Contents are not reset.
//   clk    in   clock
//   rd_en  in   capture mem[addr] into rdata on this edge
//   we     in   per-lane write enables (lane 0 = bits 7:0)
//   addr   in   word index
//   wdata  in   lane-aligned write data
//   rdata  out  registered read word
// -----------------------------------------------------------------------------
module dmem_byte_ram #(
    parameter int WORD_BITS = 15
) (
    input  logic                 clk,
    input  logic                 rd_en,
    input  logic [3:0]           we,
    input  logic [WORD_BITS-1:0] addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata
);

    localparam int DEPTH = 1 << WORD_BITS;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] rdata_reg;

            always_ff @(posedge clk) begin
                if (we[gi]) begin
                    mem[addr] <= wdata[gi*8 +: 8];
                end
                if (rd_en) begin
                    rdata_reg <= mem[addr];
                end
            end

            assign rdata[gi*8 +: 8] = rdata_reg;
        end
    endgenerate

endmodule

// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
// Byte-addressed RV32I data memory controller in front of a word RAM.
// Handles LB/LH/LW/LBU/LHU/SB/SH/SW with lane shifting and load extension.
// Accesses that cross a word boundary are split into two RAM beats when the
// macro DMEM_MISALIGNED_EN is defined, otherwise they are rejected (rsp_err).
//   clk         in   clock
//   rst_n       in   synchronous active-low reset
//   req_valid   in   request present
//   req_ready   out  request accepted this cycle if req_valid
//   req_we      in   1 = store, 0 = load
//   req_funct3  in   RV32I width/sign code
//   req_addr    in   byte address (bits above ADDR_BITS wrap)
//   req_wdata   in   right-aligned store data
//   rsp_valid   out  one-cycle completion pulse
//   rsp_rdata   out  extended load data, 0 for stores/errors
//   rsp_err     out  request rejected
// -----------------------------------------------------------------------------
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_BITS     = 17
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [2:0]               req_funct3,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     rsp_valid,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic                     rsp_err
);

    localparam int WB = ADDR_BITS - 2;

    // Request decode
    logic          accept;
    logic [1:0]    req_off;
    logic [WB-1:0] req_idx;
    logic [2:0]    req_size;
    logic [7:0]    req_be8;
    logic [63:0]   req_wd64;
    logic          req_legal;
    logic          req_cross;

    // RAM port
    logic          ram_rd;
    logic [3:0]    ram_we;
    logic [WB-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    // Response state
    logic          rsp_valid_reg, rsp_valid_next;
    logic          rsp_err_reg, rsp_err_next;
    logic          rsp_load_reg, rsp_load_next;
    logic [1:0]    rsp_off_reg;
    logic [2:0]    rsp_f3_reg;
    logic [31:0]   lo_word;
    logic [31:0]   shifted;
    logic [31:0]   ext;
    logic [31:0]   load_data;

    // Address bits above the implemented range are ignored (wrap).
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[ADDRESS_WIDTH-1:ADDR_BITS];

`ifdef DMEM_MISALIGNED_EN
    dmem_state_t   state_reg, state_next;
    logic [WB-1:0] split_idx_reg;
    logic [3:0]    split_be_reg;
    logic [31:0]   split_wd_reg;
    logic          split_we_reg;
    logic          rsp_split_reg;
    logic [31:0]   hold_reg;
    logic [31:0]   rdata_last_reg;

    assign req_ready = (state_reg == IDLE);
`else
    logic unused_split;
    assign unused_split = ^{req_be8[7:4], req_wd64[63:32]};

    assign req_ready = 1'b1;
`endif

    // Decode, RAM control and response next-state
    always_comb begin
        req_off   = req_addr[1:0];
        req_idx   = req_addr[ADDR_BITS-1:2];
        req_size  = f3_size(req_funct3);
        req_be8   = {4'b0000, f3_mask(req_funct3)} << req_off;
        req_wd64  = {32'b0, req_wdata} << {req_off, 3'b000};
        req_legal = f3_legal(req_funct3, req_we);
        req_cross = ({1'b0, req_off} + req_size) > 3'd4;
        accept    = rst_n && req_valid && req_ready;

        ram_rd         = 1'b0;
        ram_we         = 4'b0000;
        ram_addr       = req_idx;
        ram_wdata      = req_wd64[31:0];
        rsp_valid_next = 1'b0;
        rsp_err_next   = rsp_err_reg;
        rsp_load_next  = rsp_load_reg;

`ifdef DMEM_MISALIGNED_EN
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (!req_legal) begin
                        rsp_valid_next = 1'b1;
                        rsp_err_next   = 1'b1;
                        rsp_load_next  = 1'b0;
                    end else begin
                        // Beat 1 (or the only beat): low word, upper lanes.
                        ram_rd        = !req_we;
                        ram_we        = req_we ? req_be8[3:0] : 4'b0000;
                        rsp_load_next = !req_we;
                        if (req_cross) begin
                            state_next = SPLIT;
                        end else begin
                            rsp_valid_next = 1'b1;
                            rsp_err_next   = 1'b0;
                        end
                    end
                end
            end
            SPLIT: begin
                // Beat 2: next word, lower lanes. Abandoned if reset is low.
                ram_addr  = split_idx_reg;
                ram_wdata = split_wd_reg;
                if (rst_n) begin
                    ram_rd = !split_we_reg;
                    ram_we = split_we_reg ? split_be_reg : 4'b0000;
                end
                state_next     = IDLE;
                rsp_valid_next = 1'b1;
                rsp_err_next   = 1'b0;
            end
            default: state_next = IDLE;
        endcase
`else
        if (accept) begin
            rsp_valid_next = 1'b1;
            if (!req_legal || req_cross) begin
                rsp_err_next  = 1'b1;
                rsp_load_next = 1'b0;
            end else begin
                ram_rd        = !req_we;
                ram_we        = req_we ? req_be8[3:0] : 4'b0000;
                rsp_err_next  = 1'b0;
                rsp_load_next = !req_we;
            end
        end
`endif
    end

    dmem_byte_ram #(
        .WORD_BITS (WB)
    ) u_ram (
        .clk   (clk),
        .rd_en (ram_rd),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Load reassembly: the RAM output register is the newest word; for a split
    // load the older (lower-address) word sits in hold_reg.
    always_comb begin
        lo_word = ram_rdata;
`ifdef DMEM_MISALIGNED_EN
        if (rsp_split_reg) begin
            lo_word = hold_reg;
        end
`endif
        shifted = 32'({ram_rdata, lo_word} >> {rsp_off_reg, 3'b000});
        case (rsp_f3_reg[1:0])
            2'b00:   ext = rsp_f3_reg[2] ? {24'b0, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   ext = rsp_f3_reg[2] ? {16'b0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
            default: ext = shifted;
        endcase
        load_data = rsp_load_reg ? ext : 32'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_load_reg  <= 1'b0;
            rsp_off_reg   <= 2'b00;
            rsp_f3_reg    <= 3'b000;
        end else begin
            rsp_valid_reg <= rsp_valid_next;
            rsp_err_reg   <= rsp_err_next;
            rsp_load_reg  <= rsp_load_next;
            if (accept) begin
                rsp_off_reg <= req_off;
                rsp_f3_reg  <= req_funct3;
            end
        end
    end

`ifdef DMEM_MISALIGNED_EN
    // The RAM output moves on beat 1, so while in SPLIT the previously
    // presented load data is replayed from rdata_last_reg to keep rsp_rdata
    // stable between responses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            rsp_split_reg  <= 1'b0;
            rdata_last_reg <= 32'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                rsp_split_reg <= req_legal && req_cross;
            end
            if (state_reg == IDLE) begin
                rdata_last_reg <= load_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && req_cross) begin
            split_idx_reg <= req_idx + WB'(1);
            split_be_reg  <= req_be8[7:4];
            split_wd_reg  <= req_wd64[63:32];
            split_we_reg  <= req_we;
        end
        if (state_reg == SPLIT) begin
            hold_reg <= ram_rdata;
        end
    end

    assign rsp_rdata = (state_reg == SPLIT) ? rdata_last_reg : load_data;
`else
    assign rsp_rdata = load_data;
`endif

    assign rsp_valid = rsp_valid_reg;
    assign rsp_err   = rsp_err_reg;

endmodule
